// File: rtl/lfsr_rand_if.sv
// lfsr_rand_if
// Bundles the requester-side signals of the shared LFSR random source.
//   master : requester side (drives req/seed_load/seed, sees grant/rdata/...)
//   slave  : arbiter side  (drives grant/rdata/rvalid/grant_count)
// Signals:
//   req         per-requester request level
//   seed_load   load seed into the LFSR on this edge
//   seed        seed value
//   grant       registered one-hot (or zero) grant pulse
//   rdata       random word, valid while grant is nonzero
//   rvalid      |grant
//   grant_count words issued since reset (wraps at 16 bits)
interface lfsr_rand_if #(
  parameter int NUM_REQ = 4,
  parameter int LENGTH  = 8
);
  logic [NUM_REQ-1:0] req;
  logic               seed_load;
  logic [LENGTH-1:0]  seed;
  logic [NUM_REQ-1:0] grant;
  logic [LENGTH-1:0]  rdata;
  logic               rvalid;
  logic [15:0]        grant_count;

  modport master (
    output req, seed_load, seed,
    input  grant, rdata, rvalid, grant_count
  );

  modport slave (
    input  req, seed_load, seed,
    output grant, rdata, rvalid, grant_count
  );
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter
// One Fibonacci-style LFSR shared round-robin among NUM_REQ requesters.
// Each grant returns the current LFSR word and advances the LFSR once.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    lfsr_rand_if slave modport (req/seed in, grant/rdata/count out)
//
// state | meaning
// IDLE  | grant = 0, nothing issued on the last edge
// GRANT | one grant bit set, rdata valid
// SEED  | seed loaded on the last edge, grant = 0
module lfsr_rand_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LENGTH     = 8,
  parameter int FULL_CYCLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  lfsr_rand_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LENGTH-1:0]  lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LENGTH-1:0]  rdata_q, rdata_d;
  logic [15:0]        count_q, count_d;

  logic               tap_bit;
  logic               lockup;
  logic [LENGTH-1:0]  lfsr_next;
  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  // Feedback taps per width.
  if (LENGTH == 5) begin : g_tap5
    assign tap_bit = lfsr_q[4] ^ lfsr_q[2];
  end else if (LENGTH == 8) begin : g_tap8
    assign tap_bit = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end else if (LENGTH == 9) begin : g_tap9
    assign tap_bit = lfsr_q[8] ^ lfsr_q[4];
  end else begin : g_tap_top2
    assign tap_bit = lfsr_q[LENGTH-1] ^ lfsr_q[LENGTH-2];
  end

  // Inverting the feedback when the low bits are all zero splices the
  // all-zero state into the sequence, giving a full 2^LENGTH period.
  if (FULL_CYCLE != 0) begin : g_full
    assign lockup = ~|lfsr_q[LENGTH-2:0];
  end else begin : g_maximal
    assign lockup = 1'b0;
  end

  assign lfsr_next = {lfsr_q[LENGTH-2:0], tap_bit ^ lockup};

  // A requester whose grant is visible this cycle sits out one round.
  assign eligible = bus.req & ~grant_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && eligible[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    grant_d = '0;
    lfsr_d  = lfsr_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    count_d = count_q;
    if (bus.seed_load) begin
      // Pending requests are simply left for the next edge.
      state_d = SEED;
      if ((FULL_CYCLE == 0) && (bus.seed == '0)) lfsr_d = '1;
      else                                       lfsr_d = bus.seed;
    end else if (win_found) begin
      state_d = GRANT;
      grant_d = NUM_REQ'(1) << win_idx;
      rdata_d = lfsr_q;
      lfsr_d  = lfsr_next;
      last_d  = win_idx;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= '1;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.rdata       = rdata_q;
  assign bus.rvalid      = (state_q == GRANT);
  assign bus.grant_count = count_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter
// Self-checking bench: a main 4-requester 8-bit full-cycle instance checked
// against directed expectations and a behavioural model, plus an 8-bit
// maximal-length instance (seed-zero substitution) and 3/9-bit full-cycle
// instances (period coverage).
module tb_lfsr_rand_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_rand_if #(.NUM_REQ(4), .LENGTH(8)) bus8   ();
  lfsr_rand_if #(.NUM_REQ(4), .LENGTH(8)) bus8f0 ();
  lfsr_rand_if #(.NUM_REQ(4), .LENGTH(3)) bus3   ();
  lfsr_rand_if #(.NUM_REQ(4), .LENGTH(9)) bus9   ();

  lfsr_rand_arbiter #(.NUM_REQ(4), .LENGTH(8), .FULL_CYCLE(1)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8));
  lfsr_rand_arbiter #(.NUM_REQ(4), .LENGTH(8), .FULL_CYCLE(0)) dut8f0 (
    .clock(clock), .reset(reset), .bus(bus8f0));
  lfsr_rand_arbiter #(.NUM_REQ(4), .LENGTH(3), .FULL_CYCLE(1)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3));
  lfsr_rand_arbiter #(.NUM_REQ(4), .LENGTH(9), .FULL_CYCLE(1)) dut9 (
    .clock(clock), .reset(reset), .bus(bus9));

  // ---------------- behavioural reference (main instance) ----------------
  int m_s, m_last, m_grant, m_rdata, m_count;

  // Next LFSR value from tap mask parity; all-zero splice in full-cycle mode.
  function automatic int lfsr_model(int s, int len, bit fc);
    int tap;
    int din;
    case (len)
      3:       tap = 'h006;
      4:       tap = 'h00C;
      5:       tap = 'h014;
      6:       tap = 'h030;
      7:       tap = 'h060;
      8:       tap = 'h0B8;
      default: tap = 'h110;
    endcase
    din = $countones(s & tap) % 2;
    if (fc && ((s % (1 << (len - 1))) == 0)) din = din ^ 1;
    return ((s * 2) + din) % (1 << len);
  endfunction

  function automatic void model_edge(logic [3:0] r, logic sl, logic [7:0] sd, logic rs);
    int found;
    int idx;
    if (rs) begin
      m_s = 255; m_last = 3; m_grant = -1; m_rdata = 0; m_count = 0;
    end else if (sl) begin
      m_s = int'(sd);
      m_grant = -1;
    end else begin
      found = -1;
      for (int i = 1; i <= 4; i++) begin
        idx = (m_last + i) % 4;
        if (found < 0 && r[idx] && idx != m_grant) found = idx;
      end
      if (found >= 0) begin
        m_grant = found;
        m_rdata = m_s;
        m_s     = lfsr_model(m_s, 8, 1'b1);
        m_last  = found;
        m_count = (m_count + 1) % 65536;
      end else begin
        m_grant = -1;
      end
    end
  endfunction

  function automatic logic [3:0] m_grant_vec();
    logic [3:0] v;
    v = '0;
    if (m_grant >= 0) v[m_grant] = 1'b1;
    return v;
  endfunction

  // One clock edge: inputs captured before the edge feed the model, outputs
  // are sampled 1 time unit after the edge.
  task automatic tick();
    logic [3:0] r;
    logic       sl;
    logic [7:0] sd;
    logic       rs;
    r = bus8.req; sl = bus8.seed_load; sd = bus8.seed; rs = reset;
    @(posedge clock);
    model_edge(r, sl, sd, rs);
    #1;
  endtask

  task automatic idle_inputs();
    bus8.req = '0;   bus8.seed_load = 1'b0;   bus8.seed = '0;
    bus8f0.req = '0; bus8f0.seed_load = 1'b0; bus8f0.seed = '0;
    bus3.req = '0;   bus3.seed_load = 1'b0;   bus3.seed = '0;
    bus9.req = '0;   bus9.seed_load = 1'b0;   bus9.seed = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus8.grant !== 4'b0000) begin
      n_errors++; $display("FAIL reset_grant got %b exp %b", bus8.grant, 4'b0000);
    end
    n_checks++;
    if (bus8.rdata !== 8'h00) begin
      n_errors++; $display("FAIL reset_rdata got %h exp %h", bus8.rdata, 8'h00);
    end
    n_checks++;
    if (bus8.rvalid !== 1'b0) begin
      n_errors++; $display("FAIL reset_rvalid got %b exp 0", bus8.rvalid);
    end
    n_checks++;
    if (bus8.grant_count !== 16'h0000) begin
      n_errors++; $display("FAIL reset_count got %h exp 0000", bus8.grant_count);
    end
  endtask

  task automatic test_single_req();
    logic [7:0] exp_words [6];
    exp_words = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    do_reset();
    bus8.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c % 2 == 0) begin
        n_checks++;
        if (bus8.grant !== 4'b0001 || bus8.rdata !== exp_words[c/2]) begin
          n_errors++;
          $display("FAIL single_word%0d got grant %b rdata %h exp grant 0001 rdata %h",
                   c/2, bus8.grant, bus8.rdata, exp_words[c/2]);
        end
      end else begin
        n_checks++;
        if (bus8.grant !== 4'b0000 || bus8.rdata !== exp_words[c/2]) begin
          n_errors++;
          $display("FAIL single_gap%0d got grant %b rdata %h exp grant 0000 rdata %h",
                   c/2, bus8.grant, bus8.rdata, exp_words[c/2]);
        end
      end
    end
    n_checks++;
    if (bus8.grant_count !== 16'd6) begin
      n_errors++; $display("FAIL single_count got %0d exp 6", bus8.grant_count);
    end
    bus8.req = '0;
    tick();
  endtask

  task automatic test_all_req();
    logic [7:0] exp_words [6];
    logic [3:0] exp_g;
    exp_words = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    do_reset();
    bus8.req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      exp_g = 4'b0001 << (c % 4);
      n_checks++;
      if (bus8.grant !== exp_g || bus8.rdata !== exp_words[c] || bus8.rvalid !== 1'b1) begin
        n_errors++;
        $display("FAIL all_req%0d got grant %b rdata %h rvalid %b exp grant %b rdata %h rvalid 1",
                 c, bus8.grant, bus8.rdata, bus8.rvalid, exp_g, exp_words[c]);
      end
    end
    n_checks++;
    if (bus8.grant_count !== 16'd6) begin
      n_errors++; $display("FAIL all_count got %0d exp 6", bus8.grant_count);
    end
    bus8.req = '0;
    tick();
  endtask

  task automatic test_seed();
    logic [7:0] seeds [2];
    logic [7:0] first [2];
    logic [7:0] second [2];
    seeds = '{8'h00, 8'h80};
    first = '{8'h00, 8'h80};
    second = '{8'h01, 8'h00};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus8.seed_load = 1'b1;
      bus8.seed = seeds[k];
      tick();
      bus8.seed_load = 1'b0;
      bus8.req = 4'b0001;
      tick();
      n_checks++;
      if (bus8.grant !== 4'b0001 || bus8.rdata !== first[k]) begin
        n_errors++;
        $display("FAIL seed%h_first got grant %b rdata %h exp grant 0001 rdata %h",
                 seeds[k], bus8.grant, bus8.rdata, first[k]);
      end
      tick();
      tick();
      n_checks++;
      if (bus8.grant !== 4'b0001 || bus8.rdata !== second[k]) begin
        n_errors++;
        $display("FAIL seed%h_second got grant %b rdata %h exp grant 0001 rdata %h",
                 seeds[k], bus8.grant, bus8.rdata, second[k]);
      end
      bus8.req = '0;
      tick();
    end
    // Maximal-length instance replaces a zero seed with all-ones.
    bus8f0.seed_load = 1'b1;
    bus8f0.seed = 8'h00;
    tick();
    bus8f0.seed_load = 1'b0;
    bus8f0.req = 4'b0001;
    tick();
    n_checks++;
    if (bus8f0.grant !== 4'b0001 || bus8f0.rdata !== 8'hFF) begin
      n_errors++;
      $display("FAIL seed_zero_fc0 got grant %b rdata %h exp grant 0001 rdata ff",
               bus8f0.grant, bus8f0.rdata);
    end
    bus8f0.req = '0;
    tick();
  endtask

  task automatic test_seed_collision();
    do_reset();
    bus8.req = 4'b0001;          // winner 0 -> last = 0
    tick();
    bus8.req = 4'b0000;
    tick();
    bus8.seed_load = 1'b1;
    bus8.seed = 8'h5A;
    bus8.req = 4'b0110;
    tick();
    n_checks++;
    if (bus8.grant !== 4'b0000 || bus8.rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL collide_load_edge got grant %b rvalid %b exp grant 0000 rvalid 0",
               bus8.grant, bus8.rvalid);
    end
    bus8.seed_load = 1'b0;
    tick();
    // last must still be 0, so index 1 wins ahead of index 2.
    n_checks++;
    if (bus8.grant !== 4'b0010 || bus8.rdata !== 8'h5A) begin
      n_errors++;
      $display("FAIL collide_after got grant %b rdata %h exp grant 0010 rdata 5a",
               bus8.grant, bus8.rdata);
    end
    tick();
    n_checks++;
    if (bus8.grant !== 4'b0100 || bus8.rdata !== 8'(lfsr_model(32'h5A, 8, 1'b1))) begin
      n_errors++;
      $display("FAIL collide_next got grant %b rdata %h exp grant 0100 rdata %h",
               bus8.grant, bus8.rdata, 8'(lfsr_model(32'h5A, 8, 1'b1)));
    end
    bus8.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus8.req = 4'b1111;
    tick();                      // 0001
    tick();                      // 0010
    n_checks++;
    if (bus8.grant !== 4'b0010) begin
      n_errors++; $display("FAIL midrst_pre got %b exp 0010", bus8.grant);
    end
    reset = 1'b1;
    bus8.req = 4'b0110;
    tick();
    n_checks++;
    if (bus8.grant !== 4'b0000 || bus8.grant_count !== 16'd0) begin
      n_errors++;
      $display("FAIL midrst_clear got grant %b count %0d exp grant 0000 count 0",
               bus8.grant, bus8.grant_count);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus8.grant !== 4'b0010 || bus8.rdata !== 8'hFF || bus8.grant_count !== 16'd1) begin
      n_errors++;
      $display("FAIL midrst_first got grant %b rdata %h count %0d exp grant 0010 rdata ff count 1",
               bus8.grant, bus8.rdata, bus8.grant_count);
    end
    tick();
    n_checks++;
    if (bus8.grant !== 4'b0100 || bus8.rdata !== 8'hFE) begin
      n_errors++;
      $display("FAIL midrst_second got grant %b rdata %h exp grant 0100 rdata fe",
               bus8.grant, bus8.rdata);
    end
    bus8.req = '0;
    tick();
  endtask

  task automatic test_count_wrap();
    do_reset();
    bus8.req = 4'b1111;
    for (int c = 0; c < 65535; c++) tick();
    n_checks++;
    if (bus8.grant_count !== 16'hFFFF) begin
      n_errors++; $display("FAIL wrap_full got %h exp ffff", bus8.grant_count);
    end
    tick();
    n_checks++;
    if (bus8.grant_count !== 16'h0000 || bus8.rvalid !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_zero got count %h rvalid %b exp count 0000 rvalid 1",
               bus8.grant_count, bus8.rvalid);
    end
    bus8.req = '0;
    tick();
  endtask

  task automatic test_full_period();
    int seen3 [8];
    int seen9 [512];
    int exp3, exp9;
    int distinct3, distinct9;
    int bad3, bad9;
    for (int i = 0; i < 8; i++) seen3[i] = 0;
    for (int i = 0; i < 512; i++) seen9[i] = 0;
    do_reset();
    bus3.req = 4'b1111;
    bus9.req = 4'b1111;
    exp3 = 7; exp9 = 511; bad3 = 0; bad9 = 0;
    for (int t = 0; t < 512; t++) begin
      tick();
      if (t < 8) begin
        if (bus3.rvalid !== 1'b1 || int'(bus3.rdata) != exp3) bad3++;
        seen3[bus3.rdata]++;
        exp3 = lfsr_model(exp3, 3, 1'b1);
      end else if (t == 8) begin
        n_checks++;
        if (bus3.rdata !== 3'b111) begin
          n_errors++; $display("FAIL len3_return got %b exp 111", bus3.rdata);
        end
      end
      if (bus9.rvalid !== 1'b1 || int'(bus9.rdata) != exp9) bad9++;
      seen9[bus9.rdata]++;
      exp9 = lfsr_model(exp9, 9, 1'b1);
    end
    tick();
    n_checks++;
    if (bus9.rdata !== 9'h1FF) begin
      n_errors++; $display("FAIL len9_return got %h exp 1ff", bus9.rdata);
    end
    distinct3 = 0;
    for (int i = 0; i < 8; i++) if (seen3[i] == 1) distinct3++;
    distinct9 = 0;
    for (int i = 0; i < 512; i++) if (seen9[i] == 1) distinct9++;
    n_checks++;
    if (distinct3 != 8 || bad3 != 0) begin
      n_errors++;
      $display("FAIL len3_period got distinct %0d bad %0d exp distinct 8 bad 0", distinct3, bad3);
    end
    n_checks++;
    if (distinct9 != 512 || bad9 != 0) begin
      n_errors++;
      $display("FAIL len9_period got distinct %0d bad %0d exp distinct 512 bad 0", distinct9, bad9);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  eg;
    logic [7:0]  er;
    logic [15:0] ec;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus8.req       = 4'($urandom_range(0, 15));
      bus8.seed_load = ($urandom_range(0, 15) == 0);
      bus8.seed      = 8'($urandom_range(0, 255));
      reset          = ($urandom_range(0, 49) == 0);
      tick();
      eg = m_grant_vec();
      er = 8'(m_rdata);
      ec = 16'(m_count);
      n_checks++;
      if (bus8.grant !== eg || bus8.rdata !== er || bus8.rvalid !== (m_grant >= 0)
          || bus8.grant_count !== ec) begin
        n_errors++;
        $display("FAIL random%0d got grant %b rdata %h rvalid %b count %0d exp grant %b rdata %h rvalid %b count %0d",
                 c, bus8.grant, bus8.rdata, bus8.rvalid, bus8.grant_count,
                 eg, er, (m_grant >= 0), ec);
      end
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_req();
    test_all_req();
    test_seed();
    test_seed_collision();
    test_reset_mid_grant();
    test_full_period();
    test_random();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
